divider_controller: RTL
=======================

DIVIDER_CONTROLLER -- requirements
Module: divider_controller

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32: number of iteration cycles the divider core needs after its load cycle.
REQ-002 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1: request present.
REQ-005 SHALL have port in_ready, output, 1: controller can accept a request.
REQ-006 SHALL have port in_signed, input, 1: 1 means two's-complement operands, 0 means unsigned operands.
REQ-007 SHALL have port in_dividend, input, 32: dividend.
REQ-008 SHALL have port in_divisor, input, 16: divisor.
REQ-009 SHALL have port div_init, output, 1: load strobe to the unsigned 32/16 divider core.
REQ-010 SHALL have port div_dividend, output, 32: dividend magnitude sent to the core.
REQ-011 SHALL have port div_divisor, output, 16: divisor magnitude sent to the core.
REQ-012 SHALL have port div_quotient, input, 32: quotient from the core.
REQ-013 SHALL have port div_remainder, input, 16: remainder from the core.
REQ-014 SHALL have port out_valid, output, 1: result present.
REQ-015 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-016 SHALL have port out_quotient, output, 32: final quotient.
REQ-017 SHALL have port out_remainder, output, 16: final remainder.
REQ-018 SHALL have port out_div_by_zero, output, 1: divisor was zero.
REQ-019 SHALL have port out_overflow, output, 1: the quotient is not representable.

Function
REQ-020 SHALL implement the FSM states IDLE, LOAD, RUN, FIX and DONE; in_ready SHALL be 1 only in IDLE while reset is low.
REQ-021 In IDLE, when in_valid and in_ready are both 1, SHALL register the operands, the signs and in_signed.
  - The magnitudes are the absolute values when in_signed=1, and the raw values otherwise.
  - The FSM then goes to LOAD, or goes directly to DONE if in_divisor==0.
REQ-022 SHALL hold div_dividend and div_divisor stable from LOAD through FIX.
REQ-023 In LOAD, SHALL drive div_init=1 for exactly one cycle, then go to RUN; div_init SHALL be 0 in every other state.
REQ-024 In RUN, SHALL count DIV_CYCLES rising edges with a counter cleared on entry, then go to FIX.
REQ-025 In FIX, SHALL capture div_quotient and div_remainder, apply sign correction (REQ-026), and go to DONE.
REQ-026 Sign correction SHALL apply in signed mode only and SHALL use truncating division.
  - The quotient is negated (32-bit two's complement) if the dividend sign XOR the divisor sign is 1.
  - The remainder is negated (16-bit) if the dividend is negative.
REQ-027 Overflow case: signed mode, dividend 0x80000000 and divisor 0xFFFF.
  - The result SHALL be out_quotient=0x80000000, out_remainder=0, out_overflow=1.
  - out_overflow SHALL be 0 in all other cases.
REQ-028 Divide by zero SHALL produce out_quotient=0xFFFFFFFF, out_remainder=in_dividend[15:0], out_div_by_zero=1, and no div_init pulse.
REQ-029 Latency, with E = the accept edge:
  - Normal requests: out_valid rises at edge E+DIV_CYCLES+2 (E+34 by default).
  - Divide by zero: out_valid rises at edge E.
REQ-030 In DONE, out_valid=1 and all out_* SHALL be held stable until out_ready=1.
  - On that edge the FSM SHALL go to IDLE and out_valid SHALL fall.
  - There is no same-cycle re-accept.
REQ-031 in_valid outside IDLE SHALL be ignored.
  - Operand changes after acceptance SHALL NOT affect the result in flight.

Reset
REQ-032 While reset=1, the block SHALL hold: state IDLE, counter 0, and every output 0, including in_ready, div_init, out_valid and the flags.
REQ-033 Reset asserted in any state SHALL abandon the operation immediately, without waiting for a clock edge.
  - No stale result SHALL appear after release.
  - in_ready SHALL rise in the first cycle after release.

Verification
REQ-034 Unsigned test: 100/7, accepted at edge E -> div_init pulses one cycle, then out_valid at E+34 with Q=14, R=2, both flags 0.
REQ-035 Signed test: 0xFFFFFF9C / 0x0007 -> core sees 100 and 7; result Q=0xFFFFFFF2, R=0xFFFE.
REQ-036 Divide-by-zero test: dividend 0x12345678, divisor 0 -> out_valid at E, Q=0xFFFFFFFF, R=0x5678, out_div_by_zero=1, no div_init pulse.
REQ-037 Overflow test: signed 0x80000000 / 0xFFFF -> Q=0x80000000, R=0, out_overflow=1.
REQ-038 Backpressure test: out_ready held 0 for 10 cycles in DONE with in_valid held 1.
  - Outputs stay stable, in_ready stays 0, and no request is accepted.
  - When out_ready goes to 1, the FSM is in IDLE the next cycle.
REQ-039 Reset test: reset asserted during RUN cycle 10 -> out_valid=0 and div_init=0 immediately.
  - After release, unsigned 50/5 gives Q=10, R=0 at E+34.

Source files
------------

// File: rtl/divider_controller.sv
// Sequencing controller around an unsigned 32/16 iterative divider core: it takes the
// magnitudes, waits out the core's iterations and applies sign, overflow and zero-divisor fixups.
module divider_controller #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_signed,
  input  logic [31:0] in_dividend,
  input  logic [15:0] in_divisor,
  output logic        div_init,
  output logic [31:0] div_dividend,
  output logic [15:0] div_divisor,
  input  logic [31:0] div_quotient,
  input  logic [15:0] div_remainder,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_quotient,
  output logic [15:0] out_remainder,
  output logic        out_div_by_zero,
  output logic        out_overflow
);

  localparam int unsigned CntW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StFix, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            signed_q, signed_d;
  logic            dvd_neg_q, dvd_neg_d;
  logic            dvs_neg_q, dvs_neg_d;
  logic            ovf_case_q, ovf_case_d;
  logic            div_init_q, div_init_d;
  logic [31:0]     div_dividend_q, div_dividend_d;
  logic [15:0]     div_divisor_q, div_divisor_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_quotient_q, out_quotient_d;
  logic [15:0]     out_remainder_q, out_remainder_d;
  logic            out_dbz_q, out_dbz_d;
  logic            out_ovf_q, out_ovf_d;

  logic [31:0]     dvd_mag;
  logic [15:0]     dvs_mag;

  // Magnitudes of the incoming operands; raw values in unsigned mode.
  always_comb begin
    dvd_mag = (in_signed && in_dividend[31]) ? (32'd0 - in_dividend) : in_dividend;
    dvs_mag = (in_signed && in_divisor[15])  ? (16'd0 - in_divisor)  : in_divisor;
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    signed_d        = signed_q;
    dvd_neg_d       = dvd_neg_q;
    dvs_neg_d       = dvs_neg_q;
    ovf_case_d      = ovf_case_q;
    div_init_d      = 1'b0;
    div_dividend_d  = div_dividend_q;
    div_divisor_d   = div_divisor_q;
    out_valid_d     = out_valid_q;
    out_quotient_d  = out_quotient_q;
    out_remainder_d = out_remainder_q;
    out_dbz_d       = out_dbz_q;
    out_ovf_d       = out_ovf_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          signed_d   = in_signed;
          dvd_neg_d  = in_signed & in_dividend[31];
          dvs_neg_d  = in_signed & in_divisor[15];
          ovf_case_d = in_signed && (in_dividend == 32'h8000_0000) && (in_divisor == 16'hFFFF);
          if (in_divisor == 16'd0) begin
            // Zero divisor skips the core entirely and answers on the accept edge.
            state_d         = StDone;
            out_valid_d     = 1'b1;
            out_quotient_d  = 32'hFFFF_FFFF;
            out_remainder_d = in_dividend[15:0];
            out_dbz_d       = 1'b1;
            out_ovf_d       = 1'b0;
          end else begin
            state_d        = StLoad;
            div_init_d     = 1'b1;
            div_dividend_d = dvd_mag;
            div_divisor_d  = dvs_mag;
          end
        end
      end
      StLoad: begin
        state_d = StRun;
        cnt_d   = '0;
      end
      StRun: begin
        if (cnt_q == CntLast) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFix: begin
        state_d     = StDone;
        out_valid_d = 1'b1;
        out_dbz_d   = 1'b0;
        if (ovf_case_q) begin
          out_quotient_d  = 32'h8000_0000;
          out_remainder_d = 16'd0;
          out_ovf_d       = 1'b1;
        end else begin
          out_quotient_d  = (signed_q && (dvd_neg_q ^ dvs_neg_q)) ?
                            (32'd0 - div_quotient) : div_quotient;
          out_remainder_d = (signed_q && dvd_neg_q) ? (16'd0 - div_remainder) : div_remainder;
          out_ovf_d       = 1'b0;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      signed_q        <= 1'b0;
      dvd_neg_q       <= 1'b0;
      dvs_neg_q       <= 1'b0;
      ovf_case_q      <= 1'b0;
      div_init_q      <= 1'b0;
      div_dividend_q  <= '0;
      div_divisor_q   <= '0;
      out_valid_q     <= 1'b0;
      out_quotient_q  <= '0;
      out_remainder_q <= '0;
      out_dbz_q       <= 1'b0;
      out_ovf_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      signed_q        <= signed_d;
      dvd_neg_q       <= dvd_neg_d;
      dvs_neg_q       <= dvs_neg_d;
      ovf_case_q      <= ovf_case_d;
      div_init_q      <= div_init_d;
      div_dividend_q  <= div_dividend_d;
      div_divisor_q   <= div_divisor_d;
      out_valid_q     <= out_valid_d;
      out_quotient_q  <= out_quotient_d;
      out_remainder_q <= out_remainder_d;
      out_dbz_q       <= out_dbz_d;
      out_ovf_q       <= out_ovf_d;
    end
  end

  // Gated by reset so the port drops the instant reset asserts.
  assign in_ready        = (state_q == StIdle) && !reset;
  assign div_init        = div_init_q;
  assign div_dividend    = div_dividend_q;
  assign div_divisor     = div_divisor_q;
  assign out_valid       = out_valid_q;
  assign out_quotient    = out_quotient_q;
  assign out_remainder   = out_remainder_q;
  assign out_div_by_zero = out_dbz_q;
  assign out_overflow    = out_ovf_q;

endmodule
